// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath width, register address width
// and the operand forwarding source encoding.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX
    } fwd_sel_t;

endpackage

// File: rtl/id_ex_operand_fwd_mux.sv
// Forwarding select for one source operand.
// Priority is EX > MEM > WB > register file; x0 always yields zero.
module fwd_mux #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      src_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic            ex_valid_i,
    input  logic            ex_we_i,
    input  logic            ex_is_load_i,
    input  logic [4:0]      ex_rd_i,
    input  logic [XLEN-1:0] ex_data_i,
    input  logic            mem_we_i,
    input  logic [4:0]      mem_rd_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] data_o
);
    import cpu_pkg::*;

    logic     w_src_nz;
    fwd_sel_t w_sel;

    assign w_src_nz = (src_i != '0);

    // A load result is not yet available in EX, so EX never forwards a load.
    always_comb begin
        w_sel = FWD_RF;
        if (w_src_nz && ex_valid_i && ex_we_i && !ex_is_load_i && (ex_rd_i == src_i))
            w_sel = FWD_EX;
        else if (w_src_nz && mem_we_i && (mem_rd_i == src_i))
            w_sel = FWD_MEM;
        else if (w_src_nz && wb_we_i && (wb_rd_i == src_i))
            w_sel = FWD_WB;
    end

    always_comb begin
        data_o = '0;
        if (w_src_nz) begin
            case (w_sel)
                FWD_EX:  data_o = ex_data_i;
                FWD_MEM: data_o = mem_data_i;
                FWD_WB:  data_o = wb_data_i;
                default: data_o = rf_data_i;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_operand.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and a saturating count of load-use stall cycles.
module id_ex_operand #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [XLEN-1:0]  id_rD1_i,
    input  logic [XLEN-1:0]  id_rD2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_we_i,
    input  logic             id_is_load_i,
    input  logic [XLEN-1:0]  ex_alu_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_we_i,
    input  logic [XLEN-1:0]  mem_wd_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             wb_we_i,
    input  logic [XLEN-1:0]  wb_wd_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             ex_valid_o,
    output logic             ex_we_o,
    output logic             ex_is_load_o,
    output logic [4:0]       ex_rd_o,
    output logic [XLEN-1:0]  ex_op1_o,
    output logic [XLEN-1:0]  ex_op2_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    logic             r_valid;
    logic             r_we;
    logic             r_is_load;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_hazard;
    logic             w_stall;
    logic [XLEN-1:0]  w_op1;
    logic [XLEN-1:0]  w_op2;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .src_i        (id_rs1_i),
        .rf_data_i    (id_rD1_i),
        .ex_valid_i   (r_valid),
        .ex_we_i      (r_we),
        .ex_is_load_i (r_is_load),
        .ex_rd_i      (r_rd),
        .ex_data_i    (ex_alu_i),
        .mem_we_i     (mem_we_i),
        .mem_rd_i     (mem_rd_i),
        .mem_data_i   (mem_wd_i),
        .wb_we_i      (wb_we_i),
        .wb_rd_i      (wb_rd_i),
        .wb_data_i    (wb_wd_i),
        .data_o       (w_op1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .src_i        (id_rs2_i),
        .rf_data_i    (id_rD2_i),
        .ex_valid_i   (r_valid),
        .ex_we_i      (r_we),
        .ex_is_load_i (r_is_load),
        .ex_rd_i      (r_rd),
        .ex_data_i    (ex_alu_i),
        .mem_we_i     (mem_we_i),
        .mem_rd_i     (mem_rd_i),
        .mem_data_i   (mem_wd_i),
        .wb_we_i      (wb_we_i),
        .wb_rd_i      (wb_rd_i),
        .wb_data_i    (wb_wd_i),
        .data_o       (w_op2)
    );

    assign w_hazard = r_valid && r_we && r_is_load && (r_rd != '0) && id_valid_i &&
                      ((id_use_rs1_i && (id_rs1_i == r_rd)) ||
                       (id_use_rs2_i && (id_rs2_i == r_rd)));
    // A flush kills the dependent instruction, so there is nothing to wait for.
    assign w_stall  = w_hazard && !flush_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid     <= 1'b0;
            r_we        <= 1'b0;
            r_is_load   <= 1'b0;
            r_rd        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush_i || w_stall) begin
                r_valid   <= 1'b0;
                r_we      <= 1'b0;
                r_is_load <= 1'b0;
                r_rd      <= '0;
                r_op1     <= '0;
                r_op2     <= '0;
            end else begin
                r_valid   <= id_valid_i;
                r_we      <= id_we_i && id_valid_i;
                r_is_load <= id_is_load_i;
                r_rd      <= id_rd_i;
                r_op1     <= w_op1;
                r_op2     <= w_op2;
            end
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_o      = w_stall;
    assign ex_valid_o   = r_valid;
    assign ex_we_o      = r_we;
    assign ex_is_load_o = r_is_load;
    assign ex_rd_o      = r_rd;
    assign ex_op1_o     = r_op1;
    assign ex_op2_o     = r_op2;
    assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_operand.sv
// Bench for id_ex_operand: directed scenarios then random traffic, checked
// against a behavioural model of the forwarding/stall rules.
module tb_id_ex_operand;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             id_valid_i, id_use_rs1_i, id_use_rs2_i, id_we_i, id_is_load_i;
    logic [4:0]       id_rs1_i, id_rs2_i, id_rd_i, mem_rd_i, wb_rd_i;
    logic [XLEN-1:0]  id_rD1_i, id_rD2_i, ex_alu_i, mem_wd_i, wb_wd_i;
    logic             mem_we_i, wb_we_i, flush_i;
    logic             stall_o, ex_valid_o, ex_we_o, ex_is_load_o;
    logic [4:0]       ex_rd_o;
    logic [XLEN-1:0]  ex_op1_o, ex_op2_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference state: what the ID/EX register should hold.
    logic             m_valid, m_we, m_load;
    logic [4:0]       m_rd;
    logic [XLEN-1:0]  m_op1, m_op2;
    int               m_cnt;

    id_ex_operand #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_rD1_i(id_rD1_i), .id_rD2_i(id_rD2_i),
        .id_rd_i(id_rd_i), .id_we_i(id_we_i), .id_is_load_i(id_is_load_i),
        .ex_alu_i(ex_alu_i),
        .mem_rd_i(mem_rd_i), .mem_we_i(mem_we_i), .mem_wd_i(mem_wd_i),
        .wb_rd_i(wb_rd_i), .wb_we_i(wb_we_i), .wb_wd_i(wb_wd_i),
        .flush_i(flush_i), .stall_o(stall_o),
        .ex_valid_o(ex_valid_o), .ex_we_o(ex_we_o), .ex_is_load_o(ex_is_load_o),
        .ex_rd_o(ex_rd_o), .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Newest producer wins: EX result, then MEM, then WB, then register file.
    function automatic logic [XLEN-1:0] m_fwd(input logic [4:0] src, input logic [XLEN-1:0] rf);
        if (src == 0) return '0;
        if (m_valid && m_we && !m_load && m_rd == src) return ex_alu_i;
        if (mem_we_i && mem_rd_i == src) return mem_wd_i;
        if (wb_we_i && wb_rd_i == src) return wb_wd_i;
        return rf;
    endfunction

    function automatic logic m_hazard();
        if (!(m_valid && m_we && m_load && m_rd != 0 && id_valid_i)) return 1'b0;
        return (id_use_rs1_i && id_rs1_i == m_rd) || (id_use_rs2_i && id_rs2_i == m_rd);
    endfunction

    task automatic m_reset();
        m_valid = 0; m_we = 0; m_load = 0; m_rd = 0; m_op1 = 0; m_op2 = 0; m_cnt = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ":valid"}, 64'(ex_valid_o),   64'(m_valid));
        chk({tag, ":we"},    64'(ex_we_o),      64'(m_we));
        chk({tag, ":load"},  64'(ex_is_load_o), 64'(m_load));
        chk({tag, ":rd"},    64'(ex_rd_o),      64'(m_rd));
        chk({tag, ":op1"},   64'(ex_op1_o),     64'(m_op1));
        chk({tag, ":op2"},   64'(ex_op2_o),     64'(m_op2));
        chk({tag, ":cnt"},   64'(stall_cnt_o),  64'(m_cnt));
    endtask

    task automatic step(input string tag);
        logic            s;
        logic [XLEN-1:0] o1, o2;
        #1;
        s  = m_hazard() && !flush_i;
        o1 = m_fwd(id_rs1_i, id_rD1_i);
        o2 = m_fwd(id_rs2_i, id_rD2_i);
        chk({tag, ":stall"}, 64'(stall_o), 64'(s));
        @(posedge clk_i);
        #1;
        if (s && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (flush_i || s) begin
            m_valid = 0; m_we = 0; m_load = 0; m_rd = 0; m_op1 = 0; m_op2 = 0;
        end else begin
            m_valid = id_valid_i; m_we = id_we_i && id_valid_i; m_load = id_is_load_i;
            m_rd = id_rd_i; m_op1 = o1; m_op2 = o2;
        end
        chk_outputs(tag);
    endtask

    task automatic idle();
        id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_use_rs1_i = 0; id_use_rs2_i = 0;
        id_rD1_i = 0; id_rD2_i = 0; id_rd_i = 0; id_we_i = 0; id_is_load_i = 0;
        ex_alu_i = 0; mem_rd_i = 0; mem_we_i = 0; mem_wd_i = 0;
        wb_rd_i = 0; wb_we_i = 0; wb_wd_i = 0; flush_i = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic we, input logic ld);
        id_valid_i = 1; id_rd_i = rd; id_we_i = we; id_is_load_i = ld;
    endtask

    initial begin
        idle();
        m_reset();
        reset_i = 1;
        #12;
        chk_outputs("reset");
        chk("reset:stall", 64'(stall_o), 64'(0));
        @(negedge clk_i);
        reset_i = 0;

        // EX forward: add x5 in ID/EX, next instruction reads x5
        issue(5'd5, 1, 0);
        step("add_x5");
        idle(); issue(5'd0, 0, 0);
        id_rs1_i = 5; id_use_rs1_i = 1; id_rD1_i = 0; ex_alu_i = 32'h11;
        step("ex_fwd");
        chk("ex_fwd:op1_const", 64'(ex_op1_o), 64'h11);

        // Priority EX > MEM > WB
        idle(); issue(5'd7, 1, 0);
        step("prod_x7");
        idle(); issue(5'd0, 0, 0);
        id_rs1_i = 7; id_use_rs1_i = 1; id_rD1_i = 32'hF;
        ex_alu_i = 32'hA; mem_rd_i = 7; mem_we_i = 1; mem_wd_i = 32'hB;
        wb_rd_i = 7; wb_we_i = 1; wb_wd_i = 32'hC;
        step("prio_ex");
        chk("prio_ex:const", 64'(ex_op1_o), 64'hA);
        step("prio_mem");
        chk("prio_mem:const", 64'(ex_op1_o), 64'hB);
        mem_we_i = 0;
        step("prio_wb");
        chk("prio_wb:const", 64'(ex_op1_o), 64'hC);

        // x0 never forwards
        idle(); issue(5'd0, 0, 0);
        id_use_rs1_i = 1; id_use_rs2_i = 1; id_rD1_i = 32'h1; id_rD2_i = 32'h2;
        mem_rd_i = 0; mem_we_i = 1; mem_wd_i = 32'hDEAD;
        wb_rd_i = 0; wb_we_i = 1; wb_wd_i = 32'hBEEF;
        step("x0");
        chk("x0:op1_const", 64'(ex_op1_o), 64'h0);

        // Load-use: one bubble, then MEM forward
        idle(); issue(5'd3, 1, 1);
        step("lw_x3");
        idle(); issue(5'd9, 1, 0);
        id_rs2_i = 3; id_use_rs2_i = 1; id_rD2_i = 32'h77;
        step("lu_stall");
        chk("lu_stall:cnt_const", 64'(stall_cnt_o), 64'd1);
        mem_rd_i = 3; mem_we_i = 1; mem_wd_i = 32'h55;
        step("lu_mem_fwd");
        chk("lu_mem_fwd:op2_const", 64'(ex_op2_o), 64'h55);

        // Flush overrides a load-use hazard
        idle(); issue(5'd4, 1, 1);
        step("lw_x4");
        idle(); issue(5'd6, 1, 0);
        id_rs1_i = 4; id_use_rs1_i = 1; flush_i = 1;
        step("flush_hz");
        chk("flush_hz:cnt_const", 64'(stall_cnt_o), 64'd1);

        // Random traffic over a few registers to provoke collisions and saturation
        for (int i = 0; i < 400; i++) begin
            idle();
            id_valid_i   = ($urandom_range(0, 5) != 0);
            id_rs1_i     = 5'($urandom_range(0, 3));
            id_rs2_i     = 5'($urandom_range(0, 3));
            id_use_rs1_i = 1'($urandom);
            id_use_rs2_i = 1'($urandom);
            id_rD1_i     = $urandom;
            id_rD2_i     = $urandom;
            id_rd_i      = 5'($urandom_range(0, 3));
            id_we_i      = ($urandom_range(0, 3) != 0);
            id_is_load_i = ($urandom_range(0, 2) == 0);
            ex_alu_i     = $urandom;
            mem_rd_i     = 5'($urandom_range(0, 3));
            mem_we_i     = 1'($urandom);
            mem_wd_i     = $urandom;
            wb_rd_i      = 5'($urandom_range(0, 3));
            wb_we_i      = 1'($urandom);
            wb_wd_i      = $urandom;
            flush_i      = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        // Async reset between edges while a load-use stall is pending
        idle(); issue(5'd2, 1, 1);
        step("lw_x2");
        idle(); issue(5'd8, 1, 0);
        id_rs1_i = 2; id_use_rs1_i = 1; id_rD1_i = 32'h123;
        #1;
        chk("pre_rst:stall", 64'(stall_o), 64'(1));
        #1;
        reset_i = 1;
        #1;
        m_reset();
        chk_outputs("async_rst");
        chk("async_rst:stall", 64'(stall_o), 64'(0));
        #2;
        reset_i = 0;
        step("post_rst");
        chk("post_rst:op1_const", 64'(ex_op1_o), 64'h123);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_operand.md
ID_EX_OPERAND -- requirements
Module: id_ex_operand

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/data width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_i  in  1  reset, asynchronous, active-high.
REQ-005 id_valid_i  in  1  ID holds a real instruction.
REQ-006 id_rs1_i, id_rs2_i  in  5 each  source register numbers sent to the register file.
REQ-007 id_use_rs1_i, id_use_rs2_i  in  1 each  instruction actually reads rs1/rs2.
REQ-008 id_rD1_i, id_rD2_i  in  XLEN each  register-file read data (x0 already reads 0).
REQ-009 id_rd_i  in  5; id_we_i  in  1; id_is_load_i  in  1  destination, write enable, load flag.
REQ-010 ex_alu_i  in  XLEN  combinational EX result of the instruction now in ID/EX.
REQ-011 mem_rd_i  in  5; mem_we_i  in  1; mem_wd_i  in  XLEN  EX/MEM writeback info.
REQ-012 wb_rd_i  in  5; wb_we_i  in  1; wb_wd_i  in  XLEN  same signals driving register-file write port.
REQ-013 flush_i  in  1  kill ID instruction (taken branch/jump).
REQ-014 stall_o  out  1  hold PC and IF/ID this cycle (combinational).
REQ-015 ex_valid_o, ex_we_o, ex_is_load_o  out  1 each; ex_rd_o  out  5; ex_op1_o, ex_op2_o  out  XLEN  registered ID/EX contents.
REQ-016 stall_cnt_o  out  CNT_W  count of load-use stall cycles.

Function
REQ-017 Per source, forwarded value SHALL be chosen by priority EX > MEM > WB > id_rD*_i; a stage matches only if its we=1, its rd equals the source and rd != 0 (EX stage also requires ex_valid_o=1 and ex_is_load_o=0).
REQ-018 Source register 0 SHALL always yield 0 regardless of forwarding inputs.
REQ-019 WB forwarding SHALL cover the same-edge write/read case (register file writes at edge, reads combinationally).
REQ-020 Load-use hazard SHALL be: ex_valid_o & ex_we_o & ex_is_load_o & ex_rd_o!=0 & id_valid_i & ((id_use_rs1_i & id_rs1_i==ex_rd_o) | (id_use_rs2_i & id_rs2_i==ex_rd_o)).
REQ-021 stall_o SHALL equal hazard & !flush_i.
REQ-022 On rising edge: flush_i=1 -> bubble (ex_valid_o=0, ex_we_o=0, ex_is_load_o=0, ex_rd_o=0, operands 0); else stall_o=1 -> same bubble; else load ID fields with forwarded operands, ex_valid_o=id_valid_i, ex_we_o=id_we_i&id_valid_i.
REQ-023 Latency SHALL be one cycle ID -> ID/EX; load-use costs exactly one bubble, after which the load is in MEM and forwards via MEM path.
REQ-024 stall_cnt_o SHALL increment by 1 on each edge where stall_o=1, saturating at all-ones.
REQ-025 Flush and hazard simultaneous: flush wins, stall_o=0, counter unchanged.

Reset
REQ-026 reset_i=1 SHALL asynchronously clear all ID/EX outputs and stall_cnt_o to 0; stall_o thus 0.
REQ-027 Reset mid-stall SHALL discard the held instruction; first post-reset edge loads ID normally.

Structure
REQ-028 Shared package cpu_pkg SHALL hold XLEN, REG_ADDR_W=5 and enum fwd_sel_t {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}.
REQ-029 One sub-module fwd_mux (priority select for one source) SHALL be instantiated twice; pipeline register and counter stay in top.

Verification
REQ-030 EX forward: ID/EX holds add x5 (ex_alu_i=0x11), ID reads x5 with id_rD1_i=0x0 -> ex_op1_o=0x11 next edge.
REQ-031 Priority: EX, MEM, WB all rd=x7 with 0xA/0xB/0xC -> operand 0xA; drop EX -> 0xB; drop MEM -> 0xC.
REQ-032 x0: MEM we=1 rd=0 wd=0xDEAD, ID reads x0 -> operand 0, no stall.
REQ-033 Load-use: lw x3 in ID/EX, ID uses rs2=x3 -> stall_o=1 one cycle, bubble inserted, stall_cnt_o 0->1; next cycle MEM forward mem_wd_i=0x55 -> ex_op2_o=0x55.
REQ-034 Flush during load-use hazard -> stall_o=0, bubble, stall_cnt_o unchanged.
REQ-035 Assert reset_i between edges while ex_valid_o=1, stall_cnt_o=3 -> all outputs 0 immediately.
